// File: rtl/i2s_rx_deserializer.sv
// I2S-style receive deserializer: oversamples s_clk/word_select/serial_data on the system
// clock, assembles left/right words and hands complete frames out over a ready/valid stream.
module i2s_rx_deserializer #(
   parameter int NUM_BITS_DAC = 24,
   parameter int NUM_BITS     = 32
) (
   input  logic                s_axi_aclk,
   input  logic                s_axi_aresetn,
   input  logic                s_clk,
   input  logic                word_select,
   input  logic                serial_data,
   output logic [NUM_BITS-1:0] left_data,
   output logic [NUM_BITS-1:0] right_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overrun,
   output logic                frame_err
);

   typedef enum logic [1:0] {
      S_UNSYNC = 2'd0,
      S_LEFT   = 2'd1,
      S_RIGHT  = 2'd2
   } state_t;

   logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
   logic r_ws_s1, r_ws_s2;
   logic r_sd_s1, r_sd_s2;

   logic                    r_ws_prev;
   logic [5:0]              r_bit_cnt;
   logic [NUM_BITS_DAC-1:0] r_shift;
   state_t                  r_state;
   state_t                  w_state_next;

   logic [NUM_BITS-1:0] r_left_hold;
   logic [NUM_BITS-1:0] r_left_data;
   logic [NUM_BITS-1:0] r_right_data;
   logic                r_out_valid;
   logic                r_overrun;
   logic                r_frame_err;

   logic                    w_bit_edge;
   logic                    w_word_end;
   logic [NUM_BITS_DAC-1:0] w_word;
   logic [NUM_BITS-1:0]     w_word_sx;
   logic [5:0]              w_final_cnt;
   logic                    w_latch_left;
   logic                    w_frame_done;
   logic                    w_load;
   logic                    w_drop;
   logic                    w_frame_err_next;

   // All three link lines share the same synchronizer depth so they stay bit-aligned.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_sclk_s1 <= 1'b0;
         r_sclk_s2 <= 1'b0;
         r_sclk_s3 <= 1'b0;
         r_ws_s1   <= 1'b0;
         r_ws_s2   <= 1'b0;
         r_sd_s1   <= 1'b0;
         r_sd_s2   <= 1'b0;
      end else begin
         r_sclk_s1 <= s_clk;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_s3 <= r_sclk_s2;
         r_ws_s1   <= word_select;
         r_ws_s2   <= r_ws_s1;
         r_sd_s1   <= serial_data;
         r_sd_s2   <= r_sd_s1;
      end
   end

   assign w_bit_edge = r_sclk_s2 & ~r_sclk_s3;
   assign w_word_end = w_bit_edge & (r_ws_s2 != r_ws_prev);

   // Current word with this cycle's bit merged in; counts past the word width match no slot.
   generate
      for (genvar gi = 0; gi < NUM_BITS_DAC; gi++) begin : g_word_bit
         assign w_word[gi] = (r_bit_cnt == 6'(NUM_BITS_DAC - 1 - gi)) ? r_sd_s2 : r_shift[gi];
      end
   endgenerate

   assign w_word_sx   = NUM_BITS'($signed(w_word));
   assign w_final_cnt = (r_bit_cnt == 6'd63) ? 6'd63 : r_bit_cnt + 6'd1;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_ws_prev <= 1'b0;
         r_bit_cnt <= 6'd0;
         r_shift   <= '0;
      end else if (w_bit_edge) begin
         r_ws_prev <= r_ws_s2;
         if (w_word_end) begin
            r_bit_cnt <= 6'd0;
            r_shift   <= '0;
         end else begin
            r_bit_cnt <= w_final_cnt;
            r_shift   <= w_word;
         end
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) r_state <= S_UNSYNC;
      else                r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_word_end) begin
         case (r_state)
            S_UNSYNC: if (r_ws_prev) w_state_next = S_LEFT;
            S_LEFT:   w_state_next = S_RIGHT;
            S_RIGHT:  w_state_next = S_LEFT;
            default:  w_state_next = S_UNSYNC;
         endcase
      end
   end

   always_comb begin
      w_latch_left     = w_word_end & (r_state == S_LEFT);
      w_frame_done     = w_word_end & (r_state == S_RIGHT);
      w_load           = w_frame_done & (~r_out_valid | out_ready);
      w_drop           = w_frame_done & r_out_valid & ~out_ready;
      w_frame_err_next = w_word_end & (r_state != S_UNSYNC) &
                         (w_final_cnt != 6'(NUM_BITS_DAC));
   end

   // A frame completing while the held one is being accepted reloads without a bubble.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_left_hold  <= '0;
         r_left_data  <= '0;
         r_right_data <= '0;
         r_out_valid  <= 1'b0;
         r_overrun    <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         if (w_latch_left) r_left_hold <= w_word_sx;
         if (w_load) begin
            r_left_data  <= r_left_hold;
            r_right_data <= w_word_sx;
            r_out_valid  <= 1'b1;
         end else if (out_ready) begin
            r_out_valid  <= 1'b0;
         end
         r_overrun   <= w_drop;
         r_frame_err <= w_frame_err_next;
      end
   end

   assign left_data  = r_left_data;
   assign right_data = r_right_data;
   assign out_valid  = r_out_valid;
   assign overrun    = r_overrun;
   assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Scoreboard bench for i2s_rx_deserializer: directed I2S frames in, expected frames queued,
// a negedge monitor pops and compares on every accepted output frame.
module tb_i2s_rx_deserializer;

   localparam int DAC = 24;
   localparam int NB  = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_clk = 1'b0;
   logic          ws = 1'b0;
   logic          sd = 1'b0;
   logic          out_ready = 1'b0;
   logic [NB-1:0] left_data;
   logic [NB-1:0] right_data;
   logic          out_valid;
   logic          overrun;
   logic          frame_err;

   int total = 0;
   int bad = 0;
   int n_hs = 0;
   int n_ovr = 0;
   int n_ferr = 0;
   int hs0, ovr0, fe0;
   logic [63:0] sb_q[$];
   logic [63:0] mon_exp;

   always #5 clk = ~clk;

   i2s_rx_deserializer #(
      .NUM_BITS_DAC(DAC),
      .NUM_BITS    (NB)
   ) dut (
      .s_axi_aclk   (clk),
      .s_axi_aresetn(rst_n),
      .s_clk        (s_clk),
      .word_select  (ws),
      .serial_data  (sd),
      .left_data    (left_data),
      .right_data   (right_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overrun      (overrun),
      .frame_err    (frame_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            n_hs++;
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_frame: got %h_%h expected none", left_data, right_data);
            end else begin
               mon_exp = sb_q.pop_front();
               check("frame_left", 64'(left_data), 64'(mon_exp[63:32]));
               check("frame_right", 64'(right_data), 64'(mon_exp[31:0]));
            end
         end
         if (overrun)   n_ovr++;
         if (frame_err) n_ferr++;
      end
   end

   // Called at posedge+1; leaves s_clk high at posedge+1 after 8 system cycles.
   task automatic send_bit(input logic w, input logic d, input logic pulse);
      s_clk = 1'b0;
      ws    = w;
      sd    = d;
      repeat (4) @(posedge clk);
      #1 s_clk = 1'b1;
      if (pulse) begin
         repeat (2) @(posedge clk);
         #1 out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
         @(posedge clk);
         #1;
      end else begin
         repeat (4) @(posedge clk);
         #1;
      end
   endtask

   // Last bit of a word is sent with the opposite word_select (I2S one-bit lead).
   task automatic send_bits(input logic ch, input logic [31:0] data, input int n,
                            input int first, input int last, input logic pulse);
      for (int i = first; i <= last; i++)
         send_bit((i == n - 1) ? ~ch : ch, data[n-1-i], pulse && (i == n - 1));
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                             input logic pulse);
      send_bits(1'b0, l, n, 0, n - 1, 1'b0);
      send_bits(1'b1, r, n, 0, n - 1, pulse);
   endtask

   task automatic snap();
      hs0  = n_hs;
      ovr0 = n_ovr;
      fe0  = n_ferr;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_left", 64'(left_data), 64'h0);
      check("rst_right", 64'(right_data), 64'h0);
      check("rst_valid", 64'(out_valid), 64'h0);
      check("rst_overrun", 64'(overrun), 64'h0);
      check("rst_frame_err", 64'(frame_err), 64'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Clean 24-bit frames; the first one only syncs the receiver.
      snap();
      out_ready = 1'b1;
      sb_q.push_back({32'h0012_3456, 32'hFFFE_DCBA});
      sb_q.push_back({32'h0012_3456, 32'hFFFE_DCBA});
      for (int f = 0; f < 3; f++) send_frame(32'h123456, 32'hFEDCBA, 24, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("t1_frames", 64'(n_hs - hs0), 64'd2);
      check("t1_frame_err", 64'(n_ferr - fe0), 64'd0);
      check("t1_overrun", 64'(n_ovr - ovr0), 64'd0);
      check("t1_queue_empty", 64'(sb_q.size()), 64'd0);

      // Long 32-bit words keep the upper 24 bits.
      snap();
      sb_q.push_back({32'h007F_FFFF, 32'hFF80_0000});
      send_frame(32'h7FFFFF00, 32'h80000001, 32, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("t2_frames", 64'(n_hs - hs0), 64'd1);
      check("t2_frame_err", 64'(n_ferr - fe0), 64'd2);

      // Short 16-bit words are MSB-aligned with zero LSBs.
      snap();
      sb_q.push_back({32'hFF80_0100, 32'h0012_3400});
      send_frame(32'h8001, 32'h1234, 16, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("t3_frames", 64'(n_hs - hs0), 64'd1);
      check("t3_frame_err", 64'(n_ferr - fe0), 64'd2);

      // Consumer stalled over two frames: first held, second dropped.
      snap();
      out_ready = 1'b0;
      sb_q.push_back({32'h000A_0B0C, 32'h007F_FFFF});
      send_frame(32'h0A0B0C, 32'h7FFFFF, 24, 1'b0);
      send_frame(32'h111111, 32'h222222, 24, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("t4_valid_held", 64'(out_valid), 64'h1);
      check("t4_left_held", 64'(left_data), 64'h000A_0B0C);
      check("t4_right_held", 64'(right_data), 64'h007F_FFFF);
      check("t4_overrun", 64'(n_ovr - ovr0), 64'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t4_frames", 64'(n_hs - hs0), 64'd1);
      check("t4_valid_clear", 64'(out_valid), 64'h0);
      check("t4_queue_empty", 64'(sb_q.size()), 64'd0);

      // Ready arrives in the exact cycle the next frame completes.
      snap();
      out_ready = 1'b0;
      sb_q.push_back({32'h0000_0001, 32'hFFFF_FFFF});
      sb_q.push_back({32'hFF80_0000, 32'h0000_0000});
      send_frame(32'h000001, 32'hFFFFFF, 24, 1'b0);
      send_frame(32'h800000, 32'h000000, 24, 1'b1);
      check("t6_valid_b2b", 64'(out_valid), 64'h1);
      check("t6_left_new", 64'(left_data), 64'hFF80_0000);
      check("t6_right_new", 64'(right_data), 64'h0000_0000);
      check("t6_overrun", 64'(n_ovr - ovr0), 64'd0);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t6_frames", 64'(n_hs - hs0), 64'd2);
      check("t6_queue_empty", 64'(sb_q.size()), 64'd0);

      // Reset in the middle of a right word, then resume the stream.
      send_bits(1'b0, 32'h135790, 24, 0, 23, 1'b0);
      send_bits(1'b1, 32'h2468AC, 24, 0, 9, 1'b0);
      s_clk = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("t5_rst_left", 64'(left_data), 64'h0);
      check("t5_rst_right", 64'(right_data), 64'h0);
      check("t5_rst_valid", 64'(out_valid), 64'h0);
      sb_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      snap();
      send_bits(1'b1, 32'h2468AC, 24, 10, 23, 1'b0);
      sb_q.push_back({32'h000F_0F0F, 32'hFFF0_F0F0});
      send_frame(32'h0F0F0F, 32'hF0F0F0, 24, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("t5_frames", 64'(n_hs - hs0), 64'd1);
      check("t5_frame_err", 64'(n_ferr - fe0), 64'd0);
      check("t5_overrun", 64'(n_ovr - ovr0), 64'd0);
      check("t5_queue_empty", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
